btn_event_arbiter: RTL and testbench

Front-end controller that turns the three raw push-buttons (go, stop, load) into clean, single, prioritised events for the game state machine. Each button is synchronised, debounced and edge-detected, then held as a pending request. A fixed-priority arbiter presents at most one event at a time over a valid/ready handshake. The block sits between the board buttons and the game controller, so the controller never sees bounce, duplicate presses or simultaneous presses.

---
 rtl/btn_event_pkg.sv | 39 +++
 rtl/btn_debounce.sv | 46 ++++
 rtl/btn_event_arbiter.sv | 107 ++++++++++
 tb/tb_btn_event_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_event_pkg.sv
// Shared types and small helpers for the button event front-end.
package btn_event_pkg;

    typedef enum logic [1:0] {
        EVT_NONE = 2'd0,
        EVT_GO   = 2'd1,
        EVT_STOP = 2'd2,
        EVT_LOAD = 2'd3
    } evt_t;

    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_PRESENT = 1'b1
    } arb_state_t;

    localparam int unsigned NUM_BTN = 3;

    // Request vector layout is {load, stop, go}; load wins, go loses.
    function automatic evt_t pick_winner(input logic [NUM_BTN-1:0] req);
        if (req[2])      return EVT_LOAD;
        else if (req[1]) return EVT_STOP;
        else if (req[0]) return EVT_GO;
        else             return EVT_NONE;
    endfunction

    function automatic logic [NUM_BTN-1:0] evt_mask(input evt_t evt);
        case (evt)
            EVT_GO:   return 3'b001;
            EVT_STOP: return 3'b010;
            EVT_LOAD: return 3'b100;
            default:  return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] popcount3(input logic [NUM_BTN-1:0] v);
        return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, stability counter and a one-cycle
// pulse on each rising edge of the debounced level.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic rise_o
);

    localparam logic [15:0] LAST_CNT = 16'(DEBOUNCE_CYCLES - 1);

    logic        sync1_reg;
    logic        sync2_reg;
    logic        level_reg;
    logic        rise_reg;
    logic [15:0] cnt_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= raw_i;
            sync2_reg <= sync1_reg;
            rise_reg  <= 1'b0;
            // Any sample agreeing with the current level restarts the count.
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == LAST_CNT) begin
                level_reg <= sync2_reg;
                rise_reg  <= sync2_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 16'd1;
            end
        end
    end

    assign rise_o = rise_reg;

endmodule

// File: rtl/btn_event_arbiter.sv
// Turns three raw buttons into single prioritised events on a
// valid/ready interface, coalescing repeat presses into a drop count.
module btn_event_arbiter
    import btn_event_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned DROP_W          = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              go_raw_i,
    input  logic              stop_raw_i,
    input  logic              load_raw_i,
    input  logic              flush_i,
    input  logic              evt_ready_i,
    output logic              evt_valid_o,
    output evt_t              evt_o,
    output logic [2:0]        pending_o,
    output logic [DROP_W-1:0] drop_cnt_o
);

    localparam int unsigned SUM_W = DROP_W + 1;

    logic [NUM_BTN-1:0] raw_vec;
    logic [NUM_BTN-1:0] rise_vec;

    assign raw_vec = {load_raw_i, stop_raw_i, go_raw_i};

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk_i  (clk_i),
                .rst_ni (rst_ni),
                .raw_i  (raw_vec[gi]),
                .rise_o (rise_vec[gi])
            );
        end
    endgenerate

    arb_state_t         state_reg, state_next;
    evt_t               evt_reg;
    logic [NUM_BTN-1:0] pending_reg, pending_next;
    logic [DROP_W-1:0]  drop_reg, drop_next;
    logic               handshake;
    logic [NUM_BTN-1:0] clr_mask;
    logic [NUM_BTN-1:0] dup_vec;
    logic [SUM_W-1:0]   drop_sum;

    assign handshake = (state_reg == ARB_PRESENT) && evt_ready_i;

    // State register; the winner is latched only on the IDLE->PRESENT step.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= ARB_IDLE;
            evt_reg   <= EVT_NONE;
        end else begin
            state_reg <= state_next;
            if (state_reg == ARB_IDLE && state_next == ARB_PRESENT) begin
                evt_reg <= pick_winner(pending_reg);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARB_IDLE:    if (|pending_reg) state_next = ARB_PRESENT;
            ARB_PRESENT: if (handshake)    state_next = ARB_IDLE;
            default:     state_next = ARB_IDLE;
        endcase
        if (flush_i) state_next = ARB_IDLE;
    end

    always_comb begin
        evt_valid_o = (state_reg == ARB_PRESENT);
        evt_o       = evt_valid_o ? evt_reg : EVT_NONE;
    end

    // A handshake clear beats a same-cycle re-press of the presented button.
    always_comb begin
        clr_mask     = handshake ? evt_mask(evt_reg) : '0;
        dup_vec      = rise_vec & pending_reg;
        drop_sum     = {1'b0, drop_reg} + SUM_W'(popcount3(dup_vec));
        pending_next = (pending_reg | rise_vec) & ~clr_mask;
        drop_next    = drop_sum[SUM_W-1] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
        if (flush_i) begin
            pending_next = '0;
            drop_next    = drop_reg;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_reg <= '0;
            drop_reg    <= '0;
        end else begin
            pending_reg <= pending_next;
            drop_reg    <= drop_next;
        end
    end

    assign pending_o  = pending_reg;
    assign drop_cnt_o = drop_reg;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter with a handshake scoreboard.
module tb_btn_event_arbiter;
    import btn_event_pkg::*;

    localparam int unsigned DEB = 4;
    localparam int unsigned DW  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          go_raw, stop_raw, load_raw;
    logic          flush, ready;
    logic          evt_valid;
    evt_t          evt;
    logic [2:0]    pending;
    logic [DW-1:0] drop_cnt;

    int   checks   = 0;
    int   failures = 0;
    evt_t exp_q[$];

    always #5 clk = ~clk;

    btn_event_arbiter #(
        .DEBOUNCE_CYCLES(DEB),
        .DROP_W         (DW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .go_raw_i    (go_raw),
        .stop_raw_i  (stop_raw),
        .load_raw_i  (load_raw),
        .flush_i     (flush),
        .evt_ready_i (ready),
        .evt_valid_o (evt_valid),
        .evt_o       (evt),
        .pending_o   (pending),
        .drop_cnt_o  (drop_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_state(input string name, input logic [2:0] exp_pend);
        chk({name, ".valid"}, 32'(evt_valid), 32'd0);
        chk({name, ".evt"}, 32'(evt), 32'(EVT_NONE));
        chk({name, ".pending"}, 32'(pending), 32'(exp_pend));
    endtask

    // Monitor: pops the scoreboard on every accepted event and checks stability.
    logic prev_valid = 1'b0;
    evt_t prev_evt   = EVT_NONE;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (evt_valid && ready && !flush) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL hs_unexpected: got event %0d expected none at %0t", evt, $time);
                end else begin
                    evt_t e;
                    e = exp_q.pop_front();
                    if (evt !== e) begin
                        failures++;
                        $display("FAIL hs_event: got %0d expected %0d at %0t", evt, e, $time);
                    end else begin
                        $display("ok   hs_event = %0d", evt);
                    end
                end
            end
            if (evt_valid && prev_valid) begin
                checks++;
                if (evt !== prev_evt) begin
                    failures++;
                    $display("FAIL evt_stable: got %0d expected %0d at %0t", evt, prev_evt, $time);
                end
            end
            prev_valid = evt_valid;
            prev_evt   = evt;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; go_raw = 1'b0; stop_raw = 1'b0; load_raw = 1'b0;
        flush = 1'b0; ready = 1'b0;
        tick(2);
        chk_idle_state("reset", 3'b000);
        chk("reset.drop", 32'(drop_cnt), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Clean press: valid after edge 7, handshake at edge 8.
        exp_q.push_back(EVT_GO);
        go_raw = 1'b1;
        tick(7);
        chk_idle_state("press.e6", 3'b001);
        tick(1);
        chk("press.e7.valid", 32'(evt_valid), 32'd1);
        chk("press.e7.evt", 32'(evt), 32'(EVT_GO));
        ready = 1'b1;
        tick(1);
        chk_idle_state("press.e8", 3'b000);
        ready = 1'b0;
        tick(2);
        go_raw = 1'b0;
        tick(10);

        // Bounce: high periods of 2 cycles never pass a 4-cycle debounce.
        for (int i = 0; i < 10; i++) begin
            stop_raw = ~stop_raw;
            tick(2);
        end
        stop_raw = 1'b0;
        tick(10);
        chk_idle_state("bounce", 3'b000);
        chk("bounce.drop", 32'(drop_cnt), 32'd0);

        // Simultaneous go+load with ready held high.
        exp_q.push_back(EVT_LOAD);
        exp_q.push_back(EVT_GO);
        ready = 1'b1;
        go_raw = 1'b1; load_raw = 1'b1;
        tick(8);
        chk("simul.first.valid", 32'(evt_valid), 32'd1);
        chk("simul.first.evt", 32'(evt), 32'(EVT_LOAD));
        tick(1);
        chk_idle_state("simul.gap", 3'b001);
        tick(1);
        chk("simul.second.valid", 32'(evt_valid), 32'd1);
        chk("simul.second.evt", 32'(evt), 32'(EVT_GO));
        tick(1);
        chk_idle_state("simul.done", 3'b000);
        ready = 1'b0;
        go_raw = 1'b0; load_raw = 1'b0;
        tick(10);

        // Hold-off: ready low for 30 cycles while stop is pressed twice.
        exp_q.push_back(EVT_STOP);
        stop_raw = 1'b1;
        tick(7);
        stop_raw = 1'b0;
        tick(7);
        chk("hold.mid.evt", 32'(evt), 32'(EVT_STOP));
        chk("hold.mid.drop", 32'(drop_cnt), 32'd0);
        stop_raw = 1'b1;
        tick(7);
        chk("hold.second.drop", 32'(drop_cnt), 32'd1);
        stop_raw = 1'b0;
        tick(9);
        chk("hold.end.valid", 32'(evt_valid), 32'd1);
        chk("hold.end.evt", 32'(evt), 32'(EVT_STOP));
        chk("hold.end.pending", 32'(pending), 32'b010);
        chk("hold.end.drop", 32'(drop_cnt), 32'd1);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        chk_idle_state("hold.hs", 3'b000);
        tick(3);
        chk("hold.after.valid", 32'(evt_valid), 32'd0);

        // Flush beats a same-cycle handshake and discards the other request.
        go_raw = 1'b1;
        tick(8);
        chk("flush.pre.evt", 32'(evt), 32'(EVT_GO));
        stop_raw = 1'b1;
        tick(7);
        chk("flush.pre.pending", 32'(pending), 32'b011);
        chk("flush.pre.valid", 32'(evt_valid), 32'd1);
        flush = 1'b1; ready = 1'b1;
        tick(1);
        flush = 1'b0; ready = 1'b0;
        chk_idle_state("flush.post", 3'b000);
        chk("flush.post.drop", 32'(drop_cnt), 32'd1);
        tick(1);
        chk("flush.post2.valid", 32'(evt_valid), 32'd0);
        go_raw = 1'b0; stop_raw = 1'b0;
        tick(10);

        // Drop counter saturation (2-bit counter, starts at 1).
        exp_q.push_back(EVT_GO);
        go_raw = 1'b1;
        tick(8);
        chk("sat.evt", 32'(evt), 32'(EVT_GO));
        for (int i = 0; i < 3; i++) begin
            go_raw = 1'b0;
            tick(7);
            go_raw = 1'b1;
            tick(7);
            chk($sformatf("sat.drop%0d", i), 32'(drop_cnt), (i == 0) ? 32'd2 : 32'd3);
        end
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        chk_idle_state("sat.hs", 3'b000);
        go_raw = 1'b0;
        tick(10);

        // Asynchronous reset in the middle of a press that stays held.
        exp_q.push_back(EVT_GO);
        go_raw = 1'b1;
        tick(3);
        #2 rst_n = 1'b0;
        #1;
        chk_idle_state("areset", 3'b000);
        chk("areset.drop", 32'(drop_cnt), 32'd0);
        #4 rst_n = 1'b1;
        tick(6);
        chk("areset.early.valid", 32'(evt_valid), 32'd0);
        tick(2);
        chk("areset.valid", 32'(evt_valid), 32'd1);
        chk("areset.evt", 32'(evt), 32'(EVT_GO));
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        chk_idle_state("areset.hs", 3'b000);
        go_raw = 1'b0;
        tick(12);
        chk_idle_state("areset.quiet", 3'b000);

        chk("scoreboard.empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
